// File: rtl/svo_term_pkg.sv
// -----------------------------------------------------------------------------
// svo_term_pkg
// Shared constants for the HDMI text-console terminal input arbiter:
//   ASCII_LF / ASCII_CR  - line-ending characters the arbiter reacts to
//   state_t              - arbiter FSM encoding (IDLE, BUSY)
//   GNT_NONE/GNT_A/GNT_B - one-hot grant values (bit0 = A, bit1 = B)
// -----------------------------------------------------------------------------
package svo_term_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_A    = 2'b01;
    localparam logic [1:0] GNT_B    = 2'b10;

endpackage

// File: rtl/svo_term_rr_pick.sv
// -----------------------------------------------------------------------------
// svo_term_rr_pick
// Combinational two-way round-robin pick. A lone requester always wins; on
// contention the requester that did not own the terminal last wins.
// Ports:
//   a_valid  in   requester A has a byte waiting
//   b_valid  in   requester B has a byte waiting
//   last_b   in   1 = B was the previous owner, 0 = A was
//   pick     out  one-hot grant (GNT_NONE / GNT_A / GNT_B)
// -----------------------------------------------------------------------------
module svo_term_rr_pick
    import svo_term_pkg::*;
(
    input  logic       a_valid,
    input  logic       b_valid,
    input  logic       last_b,
    output logic [1:0] pick
);

    always_comb begin
        pick = GNT_NONE;
        if (a_valid && b_valid) begin
            pick = last_b ? GNT_A : GNT_B;
        end else if (a_valid) begin
            pick = GNT_A;
        end else if (b_valid) begin
            pick = GNT_B;
        end
    end

endmodule

// File: rtl/svo_term_arbiter.sv
// -----------------------------------------------------------------------------
// svo_term_arbiter
// Shares the terminal byte input between requester A (UART RX) and requester
// B (status/boot messages). One requester owns the terminal at a time and
// keeps it until it sends LF, sends BURST_MAX bytes, or stays quiet for
// IDLE_TIMEOUT cycles, so lines from the two sources never interleave.
//
// Handshake: every stream port follows AXI-stream rules. A byte moves when
// valid && ready are both high on a rising clk edge; a source holds valid and
// data stable until accepted. a_tready/b_tready are combinational from
// out_tready and registered state only (never from the requester's own tvalid).
//
// Optional build macro: SVO_TERM_ARB_CRLF_EN
//   Defined  : an LF from the owner is preceded by an inserted CR on the
//              terminal stream (the LF itself is accepted one load later).
//   Undefined: bytes pass through verbatim.
//
// Ports:
//   clk, resetn            pixel clock, asynchronous active-low reset
//   a_tvalid/a_tready/a_tdata  requester A stream
//   b_tvalid/b_tready/b_tdata  requester B stream
//   out_tvalid/out_tready/out_tdata  stream to the terminal (one-entry register)
//   grant                  one-hot current owner (bit0 = A, bit1 = B)
//   busy                   FSM is in BUSY (the FSM state itself)
// -----------------------------------------------------------------------------
module svo_term_arbiter
    import svo_term_pkg::*;
#(
    parameter int unsigned BURST_MAX    = 80,
    parameter int unsigned IDLE_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       a_tvalid,
    output logic       a_tready,
    input  logic [7:0] a_tdata,
    input  logic       b_tvalid,
    output logic       b_tready,
    input  logic [7:0] b_tdata,
    output logic       out_tvalid,
    input  logic       out_tready,
    output logic [7:0] out_tdata,
    output logic [1:0] grant,
    output logic       busy
);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_b_q, last_b_d;
    logic [7:0]  beat_q, beat_d;
    logic [15:0] idle_q, idle_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;

    logic [1:0]  pick;
    logic        is_busy;
    logic        can_load;
    logic        owner_valid;
    logic [7:0]  owner_data;
    logic        owner_ready;
    logic        accept;
    logic        load;
    logic [7:0]  load_data;
    logic        rel_lf, rel_burst, rel_idle, release_now;
    logic [8:0]  beat_inc;
    logic [16:0] idle_inc;

    svo_term_rr_pick u_pick (
        .a_valid (a_tvalid),
        .b_valid (b_tvalid),
        .last_b  (last_b_q),
        .pick    (pick)
    );

    assign is_busy  = (state_q == BUSY);
    // The output register can take a byte when empty or emptying this cycle.
    assign can_load = !out_valid_q || out_tready;

    always_comb begin
        owner_valid = 1'b0;
        owner_data  = 8'h00;
        if (grant_q[0]) begin
            owner_valid = a_tvalid;
            owner_data  = a_tdata;
        end else if (grant_q[1]) begin
            owner_valid = b_tvalid;
            owner_data  = b_tdata;
        end
    end

`ifdef SVO_TERM_ARB_CRLF_EN
    logic cr_done_q, cr_done_d;
    logic insert_cr;

    // A pending LF is held off (ready low) until its CR has been loaded.
    assign owner_ready = is_busy && can_load &&
                         !((owner_data == ASCII_LF) && !cr_done_q);
    assign insert_cr   = is_busy && can_load && owner_valid &&
                         (owner_data == ASCII_LF) && !cr_done_q;
    assign load        = (owner_valid && owner_ready) || insert_cr;
    assign load_data   = insert_cr ? ASCII_CR : owner_data;
`else
    assign owner_ready = is_busy && can_load;
    assign load        = owner_valid && owner_ready;
    assign load_data   = owner_data;
`endif

    assign accept   = owner_valid && owner_ready;
    assign a_tready = owner_ready && grant_q[0];
    assign b_tready = owner_ready && grant_q[1];

    // Release tests look at the count this beat would produce, so the
    // BURST_MAX-th byte and the IDLE_TIMEOUT-th quiet cycle release directly.
    assign beat_inc    = {1'b0, beat_q} + 9'd1;
    assign idle_inc    = {1'b0, idle_q} + 17'd1;
    assign rel_lf      = accept && (owner_data == ASCII_LF);
    assign rel_burst   = accept && (beat_inc >= 9'(BURST_MAX));
    assign rel_idle    = !owner_valid && (idle_inc >= 17'(IDLE_TIMEOUT));
    assign release_now = is_busy && (rel_lf || rel_burst || rel_idle);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_b_d    = last_b_q;
        beat_d      = beat_q;
        idle_d      = idle_q;
        out_valid_d = out_valid_q && !out_tready;
        out_data_d  = out_data_q;
`ifdef SVO_TERM_ARB_CRLF_EN
        cr_done_d   = cr_done_q;
`endif

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = load_data;
        end

        case (state_q)
            IDLE: begin
                // Grant takes effect next cycle; nothing is accepted here.
                if (pick != GNT_NONE) begin
                    state_d = BUSY;
                    grant_d = pick;
                    beat_d  = 8'd0;
                    idle_d  = 16'd0;
                end
            end
            BUSY: begin
                if (accept && (beat_q != 8'hFF)) begin
                    beat_d = beat_q + 8'd1;
                end
                if (owner_valid) begin
                    idle_d = 16'd0;
                end else if (idle_q != 16'hFFFF) begin
                    idle_d = idle_q + 16'd1;
                end
`ifdef SVO_TERM_ARB_CRLF_EN
                if (insert_cr) begin
                    cr_done_d = 1'b1;
                end else if (accept) begin
                    cr_done_d = 1'b0;
                end
`endif
                if (release_now) begin
                    state_d  = IDLE;
                    grant_d  = GNT_NONE;
                    last_b_d = grant_q[1];
                    beat_d   = 8'd0;
                    idle_d   = 16'd0;
`ifdef SVO_TERM_ARB_CRLF_EN
                    cr_done_d = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            grant_q     <= GNT_NONE;
            last_b_q    <= 1'b1;
            beat_q      <= 8'd0;
            idle_q      <= 16'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_b_q    <= last_b_d;
            beat_q      <= beat_d;
            idle_q      <= idle_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef SVO_TERM_ARB_CRLF_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cr_done_q <= 1'b0;
        end else begin
            cr_done_q <= cr_done_d;
        end
    end
`endif

    assign out_tvalid = out_valid_q;
    assign out_tdata  = out_data_q;
    assign grant      = grant_q;
    assign busy       = is_busy;

endmodule

// File: tb/tb_svo_term_arbiter.sv
// -----------------------------------------------------------------------------
// tb_svo_term_arbiter
// Self-checking bench for svo_term_arbiter (BURST_MAX = 80, IDLE_TIMEOUT = 4).
// Works in both builds; with SVO_TERM_ARB_CRLF_EN the expected terminal stream
// carries a CR before every LF.
// -----------------------------------------------------------------------------
module tb_svo_term_arbiter;
    import svo_term_pkg::*;

`ifdef SVO_TERM_ARB_CRLF_EN
    localparam int CR_EXTRA = 1;
`else
    localparam int CR_EXTRA = 0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       resetn;
    logic       a_tvalid, a_tready, b_tvalid, b_tready;
    logic [7:0] a_tdata, b_tdata;
    logic       out_tvalid, out_tready;
    logic [7:0] out_tdata;
    logic [1:0] grant;
    logic       busy;

    always #5 clk = ~clk;

    svo_term_arbiter #(
        .BURST_MAX    (80),
        .IDLE_TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .a_tvalid   (a_tvalid),
        .a_tready   (a_tready),
        .a_tdata    (a_tdata),
        .b_tvalid   (b_tvalid),
        .b_tready   (b_tready),
        .b_tdata    (b_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .grant      (grant),
        .busy       (busy)
    );

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] a_src_q[$];
    logic [7:0] b_src_q[$];
    int         b_acc = 0;
    int         n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected terminal byte; the CR insertion build adds CR ahead of LF.
    task automatic exp_byte(input logic [7:0] b);
        if (CR_EXTRA == 1 && b == ASCII_LF) exp_q.push_back(ASCII_CR);
        exp_q.push_back(b);
    endtask

    task automatic send_a(input logic [7:0] b);
        a_src_q.push_back(b);
        exp_byte(b);
    endtask

    task automatic wait_grant(input logic [1:0] want, input int budget, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (grant !== want && cnt < budget);
        check("grant_wait", {30'd0, grant}, {30'd0, want});
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || a_src_q.size() != 0 || b_src_q.size() != 0 ||
                out_tvalid || grant != GNT_NONE) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- drivers ----------------
    // Sample the handshake mid-cycle, advance the source queue just after the edge.
    initial begin
        logic a_fire;
        a_tvalid = 1'b0;
        a_tdata  = 8'h00;
        forever begin
            @(negedge clk);
            a_fire = a_tvalid && a_tready;
            @(posedge clk);
            #1;
            if (a_fire && a_src_q.size() > 0) void'(a_src_q.pop_front());
            if (a_src_q.size() > 0) begin
                a_tvalid = 1'b1;
                a_tdata  = a_src_q[0];
            end else begin
                a_tvalid = 1'b0;
            end
        end
    end

    initial begin
        logic b_fire;
        b_tvalid = 1'b0;
        b_tdata  = 8'h00;
        forever begin
            @(negedge clk);
            b_fire = b_tvalid && b_tready;
            @(posedge clk);
            #1;
            if (b_fire && b_src_q.size() > 0) begin
                void'(b_src_q.pop_front());
                b_acc++;
            end
            if (b_src_q.size() > 0) begin
                b_tvalid = 1'b1;
                b_tdata  = b_src_q[0];
            end else begin
                b_tvalid = 1'b0;
            end
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", {31'd0, out_tvalid}, 1);
                    check("hold_data", {24'd0, out_tdata}, {24'd0, prev_data});
                end
                if (out_tvalid && out_tready) begin
                    check("out_expected", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("out_data", {24'd0, out_tdata}, {24'd0, exp_q.pop_front()});
                end
                prev_stall = out_tvalid && !out_tready;
                prev_data  = out_tdata;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        resetn     = 1'b0;
        out_tready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_tvalid", {31'd0, out_tvalid}, 0);
        check("rst_out_tdata", {24'd0, out_tdata}, 0);
        check("rst_a_tready", {31'd0, a_tready}, 0);
        check("rst_b_tready", {31'd0, b_tready}, 0);
        check("rst_grant", {30'd0, grant}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);

        // "HI\n" from A: 1-cycle arbitration, three beats, release on LF.
        send_a(8'h48); send_a(8'h49); send_a(8'h0A);
        wait_grant(GNT_A, 10, n);
        check("t1_grant_lat", n, 2);
        check("t1_busy", {31'd0, busy}, 1);
        wait_grant(GNT_NONE, 10, n);
        check("t1_release_lat", n, 3 + CR_EXTRA);
        wait_drain(20);

        // Contention from reset: A, B, A, B line by line.
        apply_reset();
        a_src_q = '{8'h41, 8'h31, 8'h0A, 8'h41, 8'h32, 8'h0A};
        b_src_q = '{8'h42, 8'h31, 8'h0A, 8'h42, 8'h32, 8'h0A};
        exp_byte(8'h41); exp_byte(8'h31); exp_byte(8'h0A);
        exp_byte(8'h42); exp_byte(8'h31); exp_byte(8'h0A);
        exp_byte(8'h41); exp_byte(8'h32); exp_byte(8'h0A);
        exp_byte(8'h42); exp_byte(8'h32); exp_byte(8'h0A);
        wait_grant(GNT_A, 10, n);
        check("t2_a_first_lat", n, 2);
        wait_grant(GNT_B, 20, n);
        check("t2_a_still_valid", {31'd0, a_tvalid}, 1);
        check("t2_a_not_ready", {31'd0, a_tready}, 0);
        wait_grant(GNT_A, 20, n);
        wait_grant(GNT_B, 20, n);
        wait_grant(GNT_NONE, 20, n);
        wait_drain(40);

        // B streams 100 non-LF bytes: 80-beat burst, bubble, re-grant.
        b_acc = 0;
        for (int i = 0; i < 100; i++) begin
            b_src_q.push_back(8'(8'h30 + i % 40));
            exp_q.push_back(8'(8'h30 + i % 40));
        end
        wait_grant(GNT_B, 10, n);
        wait_grant(GNT_NONE, 200, n);
        check("t3_burst_count", b_acc, 80);
        wait_grant(GNT_B, 10, n);
        check("t3_bubble", n, 1);
        wait_grant(GNT_NONE, 100, n);
        check("t3_total", b_acc, 100);
        wait_drain(40);

        // Burst release with A pending: A wins the next arbitration.
        b_acc = 0;
        for (int i = 0; i < 90; i++) b_src_q.push_back(8'(8'h60 + i % 16));
        for (int i = 0; i < 80; i++) exp_q.push_back(8'(8'h60 + i % 16));
        exp_byte(8'h5A); exp_byte(8'h0A);
        for (int i = 80; i < 90; i++) exp_q.push_back(8'(8'h60 + i % 16));
        wait_grant(GNT_B, 10, n);
        repeat (5) @(negedge clk);
        a_src_q.push_back(8'h5A);
        a_src_q.push_back(8'h0A);
        repeat (2) @(negedge clk);
        check("t4_nonowner_valid", {31'd0, a_tvalid}, 1);
        check("t4_nonowner_ready", {31'd0, a_tready}, 0);
        wait_grant(GNT_NONE, 200, n);
        check("t4_burst_count", b_acc, 80);
        wait_grant(GNT_A, 10, n);
        check("t4_a_wins_lat", n, 1);
        wait_grant(GNT_B, 20, n);
        wait_grant(GNT_NONE, 100, n);
        check("t4_total", b_acc, 90);
        wait_drain(40);

        // Idle timeout: 2 beats then 4 quiet cycles.
        send_a(8'h41); send_a(8'h42);
        wait_grant(GNT_A, 10, n);
        wait_grant(GNT_NONE, 20, n);
        check("t5_idle_release", n, 6);
        wait_drain(20);

        // Resuming before the timeout keeps the grant.
        send_a(8'h43); send_a(8'h44);
        wait_grant(GNT_A, 10, n);
        repeat (4) @(negedge clk);
        send_a(8'h45);
        repeat (4) @(negedge clk);
        check("t6_grant_kept", {30'd0, grant}, {30'd0, GNT_A});
        wait_grant(GNT_NONE, 20, n);
        wait_drain(20);

        // Terminal stall for 10 cycles mid-line.
        for (int i = 0; i < 6; i++) send_a(8'(8'h50 + i));
        send_a(8'h0A);
        wait_grant(GNT_A, 10, n);
        @(posedge clk);
        #1 out_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t7_stall_a_tready", {31'd0, a_tready}, 0);
            check("t7_stall_valid", {31'd0, out_tvalid}, 1);
        end
        @(posedge clk);
        #1 out_tready = 1'b1;
        wait_grant(GNT_NONE, 40, n);
        wait_drain(20);

        // LF handling: CR inserted only in the CR build.
        send_a(8'h41); send_a(8'h0A);
        wait_grant(GNT_A, 10, n);
        check("t8_first_ready", {31'd0, a_tready}, 1);
        @(negedge clk);
        check("t8_lf_ready", {31'd0, a_tready}, 1 - CR_EXTRA);
        wait_grant(GNT_NONE, 10, n);
        check("t8_release_lat", n, 1 + CR_EXTRA);
        wait_drain(20);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 16; i++) send_a(8'(8'h60 + i));
        wait_grant(GNT_A, 10, n);
        repeat (3) @(negedge clk);
        check("t9_pre_valid", {31'd0, out_tvalid}, 1);
        #2 resetn = 1'b0;
        #1;
        check("t9_out_tvalid", {31'd0, out_tvalid}, 0);
        check("t9_out_tdata", {24'd0, out_tdata}, 0);
        check("t9_a_tready", {31'd0, a_tready}, 0);
        check("t9_grant", {30'd0, grant}, 0);
        check("t9_busy", {31'd0, busy}, 0);
        @(posedge clk);
        #2;
        a_src_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);

        // Recovery after reset.
        send_a(8'h4F); send_a(8'h4B); send_a(8'h0A);
        wait_grant(GNT_A, 10, n);
        check("t10_grant_lat", n, 2);
        wait_grant(GNT_NONE, 20, n);
        wait_drain(20);

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
